// File: rtl/clusterv_sram_bank_xbar.sv
// clusterv_sram_bank_xbar
// Multi-bank SRAM crossbar. Each bank has its own round-robin arbiter, so
// initiators that hit different banks are served in the same cycle. A grant
// drives the macro combinationally in cycle T. The ack/err and read data are
// returned in T+1. Addresses that decode to a bank index >= N_BANKS get an
// error response and never reach a macro.
module clusterv_sram_bank_xbar #(
    parameter int N_INITIATORS   = 5,
    parameter int N_BANKS        = 4,
    parameter int BANK_ADR_WIDTH = 9,
    parameter int ADR_WIDTH      = 32,
    parameter int DAT_WIDTH      = 32
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [N_INITIATORS*ADR_WIDTH-1:0]    t_adr,
    input  logic [N_INITIATORS*DAT_WIDTH-1:0]    t_dat_w,
    output logic [N_INITIATORS*DAT_WIDTH-1:0]    t_dat_r,
    input  logic [N_INITIATORS-1:0]              t_cyc,
    input  logic [N_INITIATORS-1:0]              t_stb,
    input  logic [N_INITIATORS-1:0]              t_we,
    input  logic [N_INITIATORS*(DAT_WIDTH/8)-1:0] t_sel,
    output logic [N_INITIATORS-1:0]              t_ack,
    output logic [N_INITIATORS-1:0]              t_err,
    output logic [N_BANKS-1:0]                   sram_csb,
    output logic [N_BANKS-1:0]                   sram_web,
    output logic [N_BANKS*(DAT_WIDTH/8)-1:0]     sram_wmask,
    output logic [N_BANKS*BANK_ADR_WIDTH-1:0]    sram_addr,
    output logic [N_BANKS*DAT_WIDTH-1:0]         sram_dat_w,
    input  logic [N_BANKS*DAT_WIDTH-1:0]         sram_dat_r
);
    localparam int BSEL_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int SEL_W  = DAT_WIDTH / 8;
    localparam int IDX_W  = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;
    localparam logic [BSEL_W:0] NB = (BSEL_W+1)'(N_BANKS);

    // Per-initiator decode
    logic [BANK_ADR_WIDTH-1:0] w_word  [N_INITIATORS];
    logic [BSEL_W-1:0]         w_bank  [N_INITIATORS];
    logic [DAT_WIDTH-1:0]      w_dat   [N_INITIATORS];
    logic [SEL_W-1:0]          w_sel   [N_INITIATORS];
    logic [N_INITIATORS-1:0]   w_pop;
    logic [N_INITIATORS-1:0]   w_req;
    logic [N_INITIATORS-1:0]   w_err;
    logic [N_INITIATORS-1:0]   w_grant;

    // Per-bank arbitration results
    logic [N_BANKS-1:0]        w_gnt_vld;
    logic [IDX_W-1:0]          w_gnt_idx [N_BANKS];
    logic [DAT_WIDTH-1:0]      w_sram_rd [N_BANKS];

    // Response state
    logic [N_INITIATORS-1:0]   r_busy;
    logic [N_INITIATORS-1:0]   r_ack_p;
    logic [N_INITIATORS-1:0]   r_err_p;
    logic [N_INITIATORS-1:0]   r_rd_p;
    logic [BSEL_W-1:0]         r_bank  [N_INITIATORS];
    logic [DAT_WIDTH-1:0]      r_dat_r [N_INITIATORS];
    logic [DAT_WIDTH-1:0]      w_rdata [N_INITIATORS];

    // Upper address bits are decoded upstream; only the low window is used here.
    logic w_unused_adr;
    assign w_unused_adr = ^t_adr;

    genvar gi, gb;
    generate
        for (gi = 0; gi < N_INITIATORS; gi++) begin : g_init
            assign w_word[gi] = t_adr[gi*ADR_WIDTH+2 +: BANK_ADR_WIDTH];
            assign w_bank[gi] = t_adr[gi*ADR_WIDTH+BANK_ADR_WIDTH+2 +: BSEL_W];
            assign w_dat[gi]  = t_dat_w[gi*DAT_WIDTH +: DAT_WIDTH];
            assign w_sel[gi]  = t_sel[gi*SEL_W +: SEL_W];
            assign w_pop[gi]  = ({1'b0, w_bank[gi]} < NB);
            // Gating with reset_n makes an asserted reset drop csb immediately.
            assign w_req[gi]  = reset_n & t_cyc[gi] & t_stb[gi] & ~r_busy[gi];
            assign w_err[gi]  = w_req[gi] & ~w_pop[gi];
            assign t_ack[gi]  = r_ack_p[gi] & t_cyc[gi];
            assign t_err[gi]  = r_err_p[gi] & t_cyc[gi];
            assign t_dat_r[gi*DAT_WIDTH +: DAT_WIDTH] = w_rdata[gi];
        end

        for (gb = 0; gb < N_BANKS; gb++) begin : g_bank
            logic [IDX_W-1:0]          r_ptr;
            logic                      w_vld;
            logic [IDX_W-1:0]          w_idx;
            logic                      w_csb, w_web;
            logic [SEL_W-1:0]          w_wmask;
            logic [BANK_ADR_WIDTH-1:0] w_addr;
            logic [DAT_WIDTH-1:0]      w_wdat;

            // Round-robin pick: first requester for this bank at or after r_ptr
            always_comb begin
                w_vld = 1'b0;
                w_idx = '0;
                for (int k = 0; k < N_INITIATORS; k++) begin
                    int idx;
                    idx = (int'(r_ptr) + k) % N_INITIATORS;
                    if (!w_vld && w_req[idx] && w_pop[idx] &&
                        (w_bank[idx] == BSEL_W'(gb))) begin
                        w_vld = 1'b1;
                        w_idx = IDX_W'(idx);
                    end
                end
            end

            // Pointer advances past the winner; holds when the bank is idle
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    r_ptr <= '0;
                else if (w_vld)
                    r_ptr <= (w_idx == IDX_W'(N_INITIATORS-1)) ? '0 : w_idx + 1'b1;
            end

            // Macro drive for the granted initiator; idle banks are parked at zero
            always_comb begin
                w_csb   = 1'b1;
                w_web   = 1'b1;
                w_wmask = '0;
                w_addr  = '0;
                w_wdat  = '0;
                if (w_vld) begin
                    w_csb   = 1'b0;
                    w_web   = ~t_we[w_idx];
                    w_wmask = t_we[w_idx] ? w_sel[w_idx] : '0;
                    w_addr  = w_word[w_idx];
                    w_wdat  = w_dat[w_idx];
                end
            end

            assign w_gnt_vld[gb] = w_vld;
            assign w_gnt_idx[gb] = w_idx;
            assign w_sram_rd[gb] = sram_dat_r[gb*DAT_WIDTH +: DAT_WIDTH];
            assign sram_csb[gb]  = w_csb;
            assign sram_web[gb]  = w_web;
            assign sram_wmask[gb*SEL_W +: SEL_W]                   = w_wmask;
            assign sram_addr[gb*BANK_ADR_WIDTH +: BANK_ADR_WIDTH]  = w_addr;
            assign sram_dat_w[gb*DAT_WIDTH +: DAT_WIDTH]           = w_wdat;
        end
    endgenerate

    // Fold per-bank grants back to per-initiator grant flags
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < N_INITIATORS; i++)
            for (int b = 0; b < N_BANKS; b++)
                if (w_gnt_vld[b] && (w_gnt_idx[b] == IDX_W'(i)))
                    w_grant[i] = 1'b1;
    end

    // Read data: macro output in the response cycle of a read, else held value
    always_comb begin
        for (int i = 0; i < N_INITIATORS; i++) begin
            w_rdata[i] = r_dat_r[i];
            if (r_rd_p[i])
                for (int b = 0; b < N_BANKS; b++)
                    if (r_bank[i] == BSEL_W'(b))
                        w_rdata[i] = w_sram_rd[b];
        end
    end

    // Response pipeline; busy blocks re-issue during the ack cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= '0;
            r_ack_p <= '0;
            r_err_p <= '0;
            r_rd_p  <= '0;
            for (int i = 0; i < N_INITIATORS; i++) begin
                r_bank[i]  <= '0;
                r_dat_r[i] <= '0;
            end
        end else begin
            r_busy  <= w_grant | w_err;
            r_ack_p <= w_grant;
            r_err_p <= w_err;
            r_rd_p  <= w_grant & ~t_we;
            for (int i = 0; i < N_INITIATORS; i++) begin
                if (w_grant[i])
                    r_bank[i] <= w_bank[i];
                r_dat_r[i] <= w_rdata[i];
            end
        end
    end
endmodule

// File: tb/tb_clusterv_sram_bank_xbar.sv
// Directed bench for clusterv_sram_bank_xbar: a 4-bank and a 3-bank build
// share one stimulus bus, each backed by simple single-port SRAM models.
module tb_clusterv_sram_bank_xbar;
    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int BW = 9;

    logic clock = 1'b0;
    logic reset_n;
    logic [N*AW-1:0] tadr;
    logic [N*DW-1:0] tdatw;
    logic [N-1:0]    tcyc, tstb, twe;
    logic [N*SW-1:0] tsel;

    logic [N*DW-1:0] datr4, datr3;
    logic [N-1:0]    ack4, err4, ack3, err3;
    logic [3:0]      csb4, web4;
    logic [4*SW-1:0] wmask4;
    logic [4*BW-1:0] addr4;
    logic [4*DW-1:0] datw4, rd4;
    logic [2:0]      csb3, web3;
    logic [3*SW-1:0] wmask3;
    logic [3*BW-1:0] addr3;
    logic [3*DW-1:0] datw3, rd3;

    logic        pl_en;
    int          pl_b;
    logic [8:0]  pl_a;
    logic [31:0] pl_d;

    int ntests = 0;
    int nfail  = 0;

    always #5 clock = ~clock;

    clusterv_sram_bank_xbar #(.N_INITIATORS(N), .N_BANKS(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .t_adr(tadr), .t_dat_w(tdatw), .t_dat_r(datr4),
        .t_cyc(tcyc), .t_stb(tstb), .t_we(twe), .t_sel(tsel), .t_ack(ack4), .t_err(err4),
        .sram_csb(csb4), .sram_web(web4), .sram_wmask(wmask4), .sram_addr(addr4),
        .sram_dat_w(datw4), .sram_dat_r(rd4));

    clusterv_sram_bank_xbar #(.N_INITIATORS(N), .N_BANKS(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .t_adr(tadr), .t_dat_w(tdatw), .t_dat_r(datr3),
        .t_cyc(tcyc), .t_stb(tstb), .t_we(twe), .t_sel(tsel), .t_ack(ack3), .t_err(err3),
        .sram_csb(csb3), .sram_web(web3), .sram_wmask(wmask3), .sram_addr(addr3),
        .sram_dat_w(datw3), .sram_dat_r(rd3));

    // SRAM models: capture on rising edge, read data valid the following cycle
    genvar gb;
    generate
        for (gb = 0; gb < 4; gb++) begin : g_m4
            logic [31:0] mem [512];
            always @(posedge clock) begin
                if (pl_en && pl_b == gb)
                    mem[pl_a] <= pl_d;
                else if (!csb4[gb]) begin
                    if (!web4[gb]) begin
                        for (int k = 0; k < SW; k++)
                            if (wmask4[gb*SW+k])
                                mem[addr4[gb*BW +: BW]][k*8 +: 8] <= datw4[gb*DW+k*8 +: 8];
                    end else
                        rd4[gb*DW +: DW] <= mem[addr4[gb*BW +: BW]];
                end
            end
        end
        for (gb = 0; gb < 3; gb++) begin : g_m3
            logic [31:0] mem [512];
            always @(posedge clock) begin
                if (!csb3[gb]) begin
                    if (!web3[gb]) begin
                        for (int k = 0; k < SW; k++)
                            if (wmask3[gb*SW+k])
                                mem[addr3[gb*BW +: BW]][k*8 +: 8] <= datw3[gb*DW+k*8 +: 8];
                    end else
                        rd3[gb*DW +: DW] <= mem[addr3[gb*BW +: BW]];
                end
            end
        end
    endgenerate

    task automatic drive(input int i, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
        tadr[i*AW +: AW]  = adr;
        tdatw[i*DW +: DW] = dat;
        tsel[i*SW +: SW]  = sel;
        twe[i]  = we;
        tcyc[i] = 1'b1;
        tstb[i] = 1'b1;
    endtask

    task automatic release_all();
        tcyc = '0;
        tstb = '0;
        twe  = '0;
    endtask

    task automatic preload(input int b, input logic [8:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_b = b; pl_a = a; pl_d = d;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        ntests++; if (ack4 !== '0) begin nfail++; $display("FAIL reset_ack got %b exp 0", ack4); end
        ntests++; if (err4 !== '0) begin nfail++; $display("FAIL reset_err got %b exp 0", err4); end
        ntests++; if (datr4 !== '0) begin nfail++; $display("FAIL reset_datr got %h exp 0", datr4); end
        ntests++; if (csb4 !== 4'hF) begin nfail++; $display("FAIL reset_csb got %b exp 1111", csb4); end
        ntests++; if (web4 !== 4'hF) begin nfail++; $display("FAIL reset_web got %b exp 1111", web4); end
        ntests++; if (wmask4 !== '0) begin nfail++; $display("FAIL reset_wmask got %h exp 0", wmask4); end
        ntests++; if (addr4 !== '0) begin nfail++; $display("FAIL reset_addr got %h exp 0", addr4); end
        ntests++; if (datw4 !== '0) begin nfail++; $display("FAIL reset_datw got %h exp 0", datw4); end
    endtask

    task automatic test_single_read();
        drive(0, 32'h0000_0804, 1'b0, 32'h0, 4'hF);
        #1;
        ntests++; if (csb4 !== 4'b1101) begin nfail++; $display("FAIL rd_csb got %b exp 1101", csb4); end
        ntests++; if (web4[1] !== 1'b1) begin nfail++; $display("FAIL rd_web got %b exp 1", web4[1]); end
        ntests++; if (addr4[BW +: BW] !== 9'd1) begin nfail++; $display("FAIL rd_addr got %0d exp 1", addr4[BW +: BW]); end
        @(posedge clock); #1;
        ntests++; if (ack4 !== 5'b00001) begin nfail++; $display("FAIL rd_ack got %b exp 00001", ack4); end
        ntests++; if (datr4[31:0] !== 32'hDEADBEEF) begin nfail++; $display("FAIL rd_data got %h exp deadbeef", datr4[31:0]); end
        ntests++; if (csb4 !== 4'hF) begin nfail++; $display("FAIL rd_busy_csb got %b exp 1111", csb4); end
        @(posedge clock); #1;
        ntests++; if (ack4 !== 5'b0) begin nfail++; $display("FAIL rd_no_reack got %b exp 00000", ack4); end
        release_all();
        @(posedge clock); #1;
    endtask

    task automatic test_byte_write();
        drive(4, 32'h0000_000C, 1'b1, 32'h1122_3344, 4'b0100);
        #1;
        ntests++; if (csb4 !== 4'b1110) begin nfail++; $display("FAIL wr_csb got %b exp 1110", csb4); end
        ntests++; if (web4[0] !== 1'b0) begin nfail++; $display("FAIL wr_web got %b exp 0", web4[0]); end
        ntests++; if (wmask4[3:0] !== 4'b0100) begin nfail++; $display("FAIL wr_wmask got %b exp 0100", wmask4[3:0]); end
        ntests++; if (datw4[31:0] !== 32'h1122_3344) begin nfail++; $display("FAIL wr_datw got %h exp 11223344", datw4[31:0]); end
        @(posedge clock); #1;
        ntests++; if (ack4 !== 5'b10000) begin nfail++; $display("FAIL wr_ack got %b exp 10000", ack4); end
        ntests++; if (datr4[4*DW +: DW] !== 32'h0) begin nfail++; $display("FAIL wr_datr_hold got %h exp 0", datr4[4*DW +: DW]); end
        release_all();
        @(posedge clock); #1;
        drive(4, 32'h0000_000C, 1'b0, 32'h0, 4'hF);
        #1;
        ntests++; if (csb4 !== 4'b1110) begin nfail++; $display("FAIL wr_rb_csb got %b exp 1110", csb4); end
        @(posedge clock); #1;
        ntests++; if (ack4 !== 5'b10000) begin nfail++; $display("FAIL wr_rb_ack got %b exp 10000", ack4); end
        ntests++; if (datr4[4*DW +: DW] !== 32'hAA22_CCDD) begin nfail++; $display("FAIL wr_rb_data got %h exp aa22ccdd", datr4[4*DW +: DW]); end
        release_all();
        @(posedge clock); #1;
    endtask

    task automatic test_contention();
        int eg [5] = '{1, 2, 3, 1, 2};
        logic [4:0]  eack;
        logic [31:0] edat;
        drive(1, 32'h0000_1004, 1'b0, 32'h0, 4'hF);
        drive(2, 32'h0000_1008, 1'b0, 32'h0, 4'hF);
        drive(3, 32'h0000_100C, 1'b0, 32'h0, 4'hF);
        for (int c = 0; c < 5; c++) begin
            #1;
            ntests++; if (csb4[2] !== 1'b0) begin nfail++; $display("FAIL rr_csb c%0d got %b exp 0", c, csb4[2]); end
            ntests++; if (addr4[2*BW +: BW] !== 9'(eg[c])) begin nfail++; $display("FAIL rr_grant c%0d got %0d exp %0d", c, addr4[2*BW +: BW], eg[c]); end
            eack = (c == 0) ? 5'b0 : 5'(1 << eg[c-1]);
            ntests++; if (ack4 !== eack) begin nfail++; $display("FAIL rr_ack c%0d got %b exp %b", c, ack4, eack); end
            if (c > 0) begin
                edat = 32'h2222_0000 + 32'(eg[c-1]);
                ntests++; if (datr4[eg[c-1]*DW +: DW] !== edat) begin nfail++; $display("FAIL rr_data c%0d got %h exp %h", c, datr4[eg[c-1]*DW +: DW], edat); end
            end
            @(posedge clock); #1;
        end
        release_all();
        @(posedge clock); #1;
        @(posedge clock); #1;
    endtask

    task automatic test_parallel();
        drive(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF);
        drive(1, 32'h0000_0814, 1'b0, 32'h0, 4'hF);
        drive(2, 32'h0000_1018, 1'b0, 32'h0, 4'hF);
        drive(3, 32'h0000_181C, 1'b0, 32'h0, 4'hF);
        #1;
        ntests++; if (csb4 !== 4'b0000) begin nfail++; $display("FAIL par_csb4 got %b exp 0000", csb4); end
        ntests++; if (addr4[3*BW +: BW] !== 9'd7) begin nfail++; $display("FAIL par_addr3 got %0d exp 7", addr4[3*BW +: BW]); end
        ntests++; if (csb3 !== 3'b000) begin nfail++; $display("FAIL par_csb3 got %b exp 000", csb3); end
        @(posedge clock); #1;
        ntests++; if (ack4 !== 5'b01111) begin nfail++; $display("FAIL par_ack4 got %b exp 01111", ack4); end
        ntests++; if (err4 !== 5'b0) begin nfail++; $display("FAIL par_err4 got %b exp 00000", err4); end
        ntests++; if (datr4[3*DW +: DW] !== 32'h3333_0007) begin nfail++; $display("FAIL par_data got %h exp 33330007", datr4[3*DW +: DW]); end
        ntests++; if (ack3 !== 5'b00111) begin nfail++; $display("FAIL unpop_ack got %b exp 00111", ack3); end
        ntests++; if (err3 !== 5'b01000) begin nfail++; $display("FAIL unpop_err got %b exp 01000", err3); end
        release_all();
        @(posedge clock); #1;
    endtask

    task automatic test_abort_reset();
        drive(0, 32'h0000_0804, 1'b0, 32'h0, 4'hF);
        #1;
        ntests++; if (csb4[1] !== 1'b0) begin nfail++; $display("FAIL abort_pre_csb got %b exp 0", csb4[1]); end
        reset_n = 1'b0;
        #1;
        ntests++; if (csb4 !== 4'hF) begin nfail++; $display("FAIL abort_csb got %b exp 1111", csb4); end
        @(posedge clock); #1;
        ntests++; if (ack4 !== 5'b0) begin nfail++; $display("FAIL abort_ack got %b exp 00000", ack4); end
        release_all();
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_cyc_drop();
        drive(2, 32'h0000_0820, 1'b1, 32'hCAFE_F00D, 4'hF);
        #1;
        ntests++; if (csb4[1] !== 1'b0) begin nfail++; $display("FAIL drop_csb got %b exp 0", csb4[1]); end
        @(posedge clock); #1;
        tcyc[2] = 1'b0;
        tstb[2] = 1'b0;
        #1;
        ntests++; if (ack4[2] !== 1'b0) begin nfail++; $display("FAIL drop_ack got %b exp 0", ack4[2]); end
        ntests++; if (err4[2] !== 1'b0) begin nfail++; $display("FAIL drop_err got %b exp 0", err4[2]); end
        @(posedge clock); #1;
        drive(2, 32'h0000_0820, 1'b0, 32'h0, 4'hF);
        #1;
        ntests++; if (csb4[1] !== 1'b0) begin nfail++; $display("FAIL drop_next_csb got %b exp 0", csb4[1]); end
        @(posedge clock); #1;
        ntests++; if (ack4[2] !== 1'b1) begin nfail++; $display("FAIL drop_next_ack got %b exp 1", ack4[2]); end
        ntests++; if (datr4[2*DW +: DW] !== 32'hCAFE_F00D) begin nfail++; $display("FAIL drop_commit got %h exp cafef00d", datr4[2*DW +: DW]); end
        release_all();
        @(posedge clock); #1;
    endtask

    initial begin
        reset_n = 1'b0;
        tadr = '0; tdatw = '0; tsel = '0;
        tcyc = '0; tstb = '0; twe = '0;
        pl_en = 1'b0; pl_b = 0; pl_a = '0; pl_d = '0;
        @(posedge clock); #1;
        preload(1, 9'd1, 32'hDEAD_BEEF);
        preload(0, 9'd3, 32'hAABB_CCDD);
        preload(2, 9'd1, 32'h2222_0001);
        preload(2, 9'd2, 32'h2222_0002);
        preload(2, 9'd3, 32'h2222_0003);
        preload(3, 9'd7, 32'h3333_0007);
        test_reset();
        reset_n = 1'b1;
        @(posedge clock); #1;
        test_single_read();
        test_byte_write();
        test_contention();
        test_parallel();
        test_abort_reset();
        test_cyc_drop();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/clusterv_sram_bank_xbar.md
Name: clusterv_sram_bank_xbar

Overview:
- Parametrised multi-bank SRAM subsystem for the clusterv system interconnect.
- Sits on the SRAM target port of the system Wishbone interconnect. Also serves as a direct crossbar for tile/DMA initiators.
- Drives N_BANKS sky130 OpenRAM single-port macros. Each bank has its own round-robin arbiter, so initiators hitting different banks proceed in the same cycle.
- Classic Wishbone, one-cycle read/write ack, error response for unpopulated banks.

Parameters:
- N_INITIATORS, 5, number of Wishbone target ports (tiles + DMA).
- N_BANKS, 4, number of SRAM macros, 1..16; non-power-of-2 allowed.
- BANK_ADR_WIDTH, 9, word-address width of one macro (512 words).
- ADR_WIDTH, 32, Wishbone byte-address width.
- DAT_WIDTH, 32, data width; must be a multiple of 8.
- Derived: BSEL_W = max(1, clog2(N_BANKS)); SEL_W = DAT_WIDTH/8.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- t_adr  in  N_INITIATORS*ADR_WIDTH  per-initiator byte address
- t_dat_w  in  N_INITIATORS*DAT_WIDTH  write data
- t_dat_r  out  N_INITIATORS*DAT_WIDTH  read data
- t_cyc  in  N_INITIATORS  cycle valid
- t_stb  in  N_INITIATORS  strobe
- t_we  in  N_INITIATORS  write enable
- t_sel  in  N_INITIATORS*SEL_W  byte selects
- t_ack  out  N_INITIATORS  transfer acknowledge
- t_err  out  N_INITIATORS  error (unpopulated bank)
- sram_csb  out  N_BANKS  chip select, active-low
- sram_web  out  N_BANKS  write enable, active-low
- sram_wmask  out  N_BANKS*SEL_W  byte write mask
- sram_addr  out  N_BANKS*BANK_ADR_WIDTH  word address
- sram_dat_w  out  N_BANKS*DAT_WIDTH  write data
- sram_dat_r  in  N_BANKS*DAT_WIDTH  read data; valid the cycle after the capture edge

Behaviour:
- Reset (async assert, sync-released use): t_ack=0, t_err=0, t_dat_r=0, sram_csb all 1, sram_web all 1, wmask/addr/dat_w=0, all RR pointers=0, all busy flags=0. Assertion mid-transfer aborts it; no ack follows. A write already captured by the macro stands.
- Decode per initiator i:
  - word = adr[BANK_ADR_WIDTH+1:2]
  - bank = adr[BANK_ADR_WIDTH+BSEL_W+1 : BANK_ADR_WIDTH+2]
  - Upper address bits ignored; the upstream interconnect has already decoded the window.
- Request: req_i = cyc_i & stb_i & ~busy_i.
  - busy_i is set on grant or error, cleared the following cycle.
  - busy_i prevents re-issuing a transfer whose stb is still high during its ack cycle.
- Per-bank arbiter:
  - Among req_i targeting bank b, grant the first index at or after ptr_b (wrapping).
  - On grant, ptr_b <= granted+1 mod N_INITIATORS. Without a grant, ptr_b holds.
  - Losers stay pending, unacked, and re-arbitrate next cycle.
  - An initiator targets only one bank, so it wins at most one grant.
- Cycle T (grant), combinational to bank b:
  - sram_csb[b]=0, sram_web[b]=~we, sram_addr=word, sram_dat_w=dat_w.
  - sram_wmask = we ? sel : 0.
  - Ungranted banks: csb=1, web=1.
- Cycle T+1 (response):
  - t_ack_i=1 if cyc_i still high.
  - For reads, t_dat_r_i = sram_dat_r of the bank registered at T. For writes, t_dat_r holds its previous value.
  - One-cycle pulse; back-to-back transfers from one initiator are possible every 2 cycles.
- Unpopulated bank (bank >= N_BANKS): no SRAM access, no arbitration. t_err_i=1 at T+1 (if cyc high), t_ack_i=0.
- cyc dropped before T+1: ack/err suppressed, busy still clears, write still committed.
- sel=0 write: csb asserted with wmask 0; acked normally.
- Throughput: up to min(N_INITIATORS, N_BANKS) transfers per cycle.

Test Plan:
- Reset then single read: initiator 0 read adr 0x0000_0804 (bank 1, word 1, bank holds 0xDEADBEEF) -> T: csb[1]=0, web[1]=1, addr=1. T+1: ack0=1, dat_r0=0xDEADBEEF. Ack never repeats while stb is held through T+1.
- Byte write: initiator 4 writes 0x11223344 to 0x0C, sel=0b0100 -> csb[0]=0, web[0]=0, wmask[0]=0b0100, ack at T+1. Readback -> only byte 2 changed (0x22).
- Same-bank contention: initiators 1, 2, 3 read bank 2 continuously from reset (ptr=0) -> grants in order 1, 2, 3, then 1 again. None starved; each sees one ack per grant.
- Parallel banks: initiators 0..3 each access a distinct bank in the same cycle -> all four csb low together and all four acks in the same cycle.
- N_BANKS=3 build: access to bank index 3 -> err=1 at T+1, ack=0, no csb asserted. Bank 2 access unaffected.
- Abort: assert reset_n=0 in the grant cycle -> no ack, csb returns to 1 immediately. Drop cyc at T+1 in another run -> no ack/err, and the next request from that initiator is granted normally.
